display_scan_ctrl: RTL and testbench



---
 rtl/display_pkg.sv | 22 ++
 rtl/bin2bcd_seq.sv | 83 ++++++++
 rtl/display_scan_ctrl.sv | 85 ++++++++
 tb/tb_display_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  localparam int unsigned BCD_W = 4;

  // Largest value representable in n decimal digits.
  function automatic longint unsigned max_dec(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 iteration per cycle, then a commit cycle.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BIN_W    = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*N_DIGITS-1:0] bcd,
  output logic                      ovf
);

  localparam int unsigned DW            = BCD_W * N_DIGITS;
  localparam int unsigned ITER_W        = $clog2(BIN_W + 1);
  localparam logic [ITER_W-1:0] LastIter = ITER_W'(BIN_W - 1);
  localparam longint unsigned MaxVal    = max_dec(N_DIGITS);

  conv_state_t       state_q;
  logic [DW-1:0]     scr_q;
  logic [DW-1:0]     scr_adj;
  logic [BIN_W-1:0]  sh_q;
  logic [ITER_W-1:0] iter_q;
  logic              ovf_pend_q;
  logic              ovf_q;

  // Scratch only keeps N_DIGITS nibbles; lower nibbles never depend on higher ones,
  // so truncation is harmless and out-of-range values are forced to all 9s anyway.
  always_comb begin
    scr_adj = scr_q;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (scr_q[k*BCD_W +: BCD_W] >= 4'd5) begin
        scr_adj[k*BCD_W +: BCD_W] = scr_q[k*BCD_W +: BCD_W] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scr_q      <= '0;
      sh_q       <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sh_q       <= bin;
            scr_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= (64'(bin) > MaxVal);
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          {scr_q, sh_q} <= {scr_adj, sh_q} << 1;
          if (iter_q == LastIter) begin
            state_q <= COMMIT;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        COMMIT: begin
          ovf_q   <= ovf_pend_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == COMMIT);
  assign bcd  = ovf_pend_q ? {N_DIGITS{4'h9}} : scr_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Converts a loaded binary value to BCD and scans it round-robin over common-anode digits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned BIN_W       = 14,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    bin_in,
  input  logic                load,
  input  logic                blank_lz,
  output logic                busy,
  output logic                overflow,
  output logic [BCD_W-1:0]    bcd_out,
  output logic [N_DIGITS-1:0] digit_en_n
);

  localparam int unsigned DW    = BCD_W * N_DIGITS;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic                conv_done;
  logic [DW-1:0]       conv_bcd;
  logic [DW-1:0]       disp_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [N_DIGITS-1:0] lz;
  logic                blank;
  logic [BCD_W-1:0]    bcd_d;
  logic [N_DIGITS-1:0] en_n_d;

  // Loads during a conversion are dropped because the converter only samples start in IDLE.
  bin2bcd_seq #(
    .N_DIGITS (N_DIGITS),
    .BIN_W    (BIN_W)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (bin_in),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (overflow)
  );

  // lz[k] is set when nibbles k..N_DIGITS-1 are all zero.
  always_comb begin
    logic z;
    z  = 1'b1;
    lz = '0;
    for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
      z     = z & (disp_q[k*BCD_W +: BCD_W] == '0);
      lz[k] = z;
    end
    blank  = blank_lz && (idx_q != '0) && lz[idx_q];
    bcd_d  = blank ? '0 : disp_q[idx_q*BCD_W +: BCD_W];
    en_n_d = blank ? '1 : ~(N_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      bcd_out    <= '0;
      digit_en_n <= ~N_DIGITS'(1);
    end else begin
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (conv_done) begin
        disp_q <= conv_bcd;
      end
      bcd_out    <= bcd_d;
      digit_en_n <= en_n_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short refresh period.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin_in;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic        overflow;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en_n;

  int n_assert = 0;
  int n_fail   = 0;

  display_scan_ctrl #(
    .N_DIGITS    (4),
    .BIN_W       (14),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bin_in     (bin_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .busy       (busy),
    .overflow   (overflow),
    .bcd_out    (bcd_out),
    .digit_en_n (digit_en_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [13:0] v, output int n);
    bin_in = v;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
  endtask

  // Watches one full scan period and records what each digit slot displayed.
  task automatic scan(output logic [15:0] shown, output logic [3:0] seen,
                      output int nblank, output int nbad);
    logic hit;
    shown  = '0;
    seen   = '0;
    nblank = 0;
    nbad   = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (digit_en_n == ~(4'b0001 << k)) begin
          shown[k*4 +: 4] = bcd_out;
          seen[k]         = 1'b1;
          hit             = 1'b1;
        end
      end
      if (digit_en_n == 4'b1111) begin
        nblank++;
        if (bcd_out != 4'h0) nbad++;
      end else if (!hit) begin
        nbad++;
      end
    end
  endtask

  task automatic chk_scan(input string tag, input logic [15:0] exp_shown,
                          input logic [3:0] exp_seen, input int exp_blank);
    logic [15:0] shown;
    logic [3:0]  seen;
    int          nblank;
    int          nbad;
    scan(shown, seen, nblank, nbad);
    chk({tag, "_shown"}, 32'(shown), 32'(exp_shown));
    chk({tag, "_seen"}, 32'(seen), 32'(exp_seen));
    chk({tag, "_nblank"}, nblank, exp_blank);
    chk({tag, "_nbad"}, nbad, 0);
  endtask

  initial begin
    int n;
    int exp_idx;
    rst      = 1'b1;
    load     = 1'b0;
    bin_in   = '0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, then the idle walk: digit 0 holds through the first wrap plus the output delay.
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_bcd", bcd_out, 4'h0);
    chk("rst_en", digit_en_n, 4'b1110);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_idx = (k <= 4) ? 0 : ((k - 1) / 4) % 4;
      chk($sformatf("walk_en_%0d", k), digit_en_n, ~(32'd1 << exp_idx) & 32'hf);
      chk($sformatf("walk_bcd_%0d", k), bcd_out, 4'h0);
    end

    // Basic conversion.
    do_load(14'd1234, n);
    chk("busy_len_1234", n, 15);
    chk("ovf_1234", overflow, 1'b0);
    chk_scan("disp_1234", 16'h1234, 4'hf, 0);

    // Overflow and the 9999 / 10000 boundary.
    do_load(14'd12345, n);
    chk("busy_len_12345", n, 15);
    chk("ovf_12345", overflow, 1'b1);
    chk_scan("disp_12345", 16'h9999, 4'hf, 0);
    do_load(14'd9999, n);
    chk("ovf_9999", overflow, 1'b0);
    chk_scan("disp_9999", 16'h9999, 4'hf, 0);
    do_load(14'd10000, n);
    chk("ovf_10000", overflow, 1'b1);
    do_load(14'd7, n);
    chk("ovf_7", overflow, 1'b0);
    chk_scan("disp_7", 16'h0007, 4'hf, 0);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(14'd40, n);
    chk_scan("blank_40", 16'h0040, 4'b0011, 8);
    do_load(14'd0, n);
    chk_scan("blank_0", 16'h0000, 4'b0001, 12);
    blank_lz = 1'b0;

    // A load during conversion is dropped.
    bin_in = 14'd1234;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bin_in = 14'd9999;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
    chk("ign_busy_len", n, 12);
    repeat (3) @(negedge clk);
    chk("ign_no_requeue", busy, 1'b0);
    chk_scan("ign_disp", 16'h1234, 4'hf, 0);

    // Reset in the middle of a conversion.
    bin_in = 14'd5678;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_bcd", bcd_out, 4'h0);
    chk("mid_rst_en", digit_en_n, 4'b1110);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk_scan("post_rst_disp", 16'h0000, 4'hf, 0);
    chk("post_rst_busy2", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
